// File: rtl/cis_scan_ctrl.sv
// Contact-image-sensor line-scan controller: sensor/ADC clocking, start pulse,
// LED sequencing and a latency-compensated valid/ready pixel stream.
module cis_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int PIXELS  = 2592,
  parameter int ADC_W   = 8,
  parameter int ADC_LAT = 2,
  parameter int INT_PAD = 8
) (
  input  logic             USB_CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             COLOR_MODE,
  input  logic [ADC_W-1:0] ADC_DATA,
  output logic             CIS_CLK,
  output logic             CIS_SP,
  output logic             CIS_MODE,
  output logic             CIS_LED_RED,
  output logic             CIS_LED_GREEN,
  output logic             CIS_LED_BLUE,
  output logic             ADC_CLK,
  output logic [ADC_W-1:0] PIX_DATA,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             PIX_FIRST,
  output logic [1:0]       PIX_COLOR,
  output logic             OVERRUN,
  output logic             SCOPE_SYNC
);

  // state | meaning
  // IDLE  | scanning stopped, dividers and LEDs off
  // SP    | one pixel period with the sensor start pulse high
  // READ  | PIXELS+ADC_LAT pixel periods of ADC capture
  // PAD   | INT_PAD idle pixel periods for integration
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SP   = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_PAD  = 2'd3;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(PIXELS + ADC_LAT + INT_PAD + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(PIXELS + ADC_LAT - 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'((INT_PAD > 0) ? INT_PAD - 1 : 0);
  localparam logic [CNT_W-1:0] FIRST_PIX = CNT_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0] PIX_CNT   = CNT_W'(PIXELS);
  localparam logic             NO_PAD    = (INT_PAD == 0);

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [1:0]       color_ptr;
  logic             line_rgb;
  logic             tick;
  logic             capture;
  logic             line_end;
  logic             lit;

  assign tick = (state != S_IDLE) && (div_cnt == DIV_LAST);

  // per_cnt counts READ periods down; the last PIXELS of them carry real pixels
  assign capture  = tick && (state == S_READ) && (per_cnt < PIX_CNT);
  assign line_end = tick && (per_cnt == '0) &&
                    ((state == S_PAD) || ((state == S_READ) && NO_PAD));

  always_ff @(posedge USB_CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      per_cnt   <= '0;
      color_ptr <= 2'd0;
      line_rgb  <= 1'b0;
      ADC_CLK   <= 1'b1;
      PIX_DATA  <= '0;
      PIX_VALID <= 1'b0;
      PIX_FIRST <= 1'b0;
      PIX_COLOR <= 2'd0;
      OVERRUN   <= 1'b0;
    end else begin
      ADC_CLK <= ~CIS_CLK;

      if ((state == S_IDLE) || tick) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;

      case (state)
        S_IDLE: if (ENABLE) begin
          state     <= S_SP;
          per_cnt   <= '0;
          line_rgb  <= COLOR_MODE;
          color_ptr <= 2'd0;
        end
        S_SP: if (tick) begin
          state   <= S_READ;
          per_cnt <= READ_LAST;
        end
        S_READ, S_PAD: if (tick) begin
          if (per_cnt == '0) begin
            state   <= S_PAD;
            per_cnt <= PAD_LAST;
          end else begin
            per_cnt <= per_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // line boundary overrides the per-state transition above
      if (line_end) begin
        if (ENABLE) begin
          state     <= S_SP;
          per_cnt   <= '0;
          line_rgb  <= COLOR_MODE;
          color_ptr <= (color_ptr == 2'd2) ? 2'd0 : color_ptr + 2'd1;
        end else begin
          state     <= S_IDLE;
          color_ptr <= 2'd0;
        end
      end

      if (capture) begin
        if (PIX_VALID && !PIX_READY) begin
          OVERRUN <= 1'b1;
        end else begin
          PIX_DATA  <= ADC_DATA;
          PIX_VALID <= 1'b1;
          PIX_FIRST <= (per_cnt == FIRST_PIX);
          PIX_COLOR <= line_rgb ? color_ptr : 2'd3;
        end
      end else if (PIX_VALID && PIX_READY) begin
        PIX_VALID <= 1'b0;
      end
    end
  end

  assign lit           = (state != S_IDLE);
  assign CIS_CLK       = lit && (div_cnt < DIV_HALF);
  assign CIS_SP        = (state == S_SP);
  assign SCOPE_SYNC    = CIS_SP;
  assign CIS_MODE      = 1'b1;
  assign CIS_LED_RED   = lit && (!line_rgb || (color_ptr == 2'd0));
  assign CIS_LED_GREEN = lit && (!line_rgb || (color_ptr == 2'd1));
  assign CIS_LED_BLUE  = lit && (!line_rgb || (color_ptr == 2'd2));

endmodule

// File: tb/tb_cis_scan_ctrl.sv
// Bench for cis_scan_ctrl: directed scan scenarios then randomized traffic,
// checked every cycle against a line-position reference model.
module tb_cis_scan_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int PIXELS   = 16;
  localparam int ADC_W    = 8;
  localparam int ADC_LAT  = 2;
  localparam int INT_PAD  = 3;
  localparam int LINE_CYC = (1 + PIXELS + ADC_LAT + INT_PAD) * CLK_DIV;

  logic             usb_clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             color_mode = 1'b0;
  logic             pix_ready = 1'b1;
  logic [ADC_W-1:0] adc_data = '0;
  logic             cis_clk, cis_sp, cis_mode, led_r, led_g, led_b, adc_clk;
  logic             pix_valid, pix_first, overrun, scope_sync;
  logic [ADC_W-1:0] pix_data;
  logic [1:0]       pix_color;

  int n_checks = 0;
  int n_fail   = 0;

  bit ramp_mode = 1'b1;
  bit measure   = 1'b0;
  bit rgb_watch = 1'b0;
  int rgb_idx   = 0;

  cis_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .PIXELS(PIXELS), .ADC_W(ADC_W),
    .ADC_LAT(ADC_LAT), .INT_PAD(INT_PAD)
  ) dut (
    .USB_CLK(usb_clk), .RST(rst), .ENABLE(enable), .COLOR_MODE(color_mode),
    .ADC_DATA(adc_data), .CIS_CLK(cis_clk), .CIS_SP(cis_sp), .CIS_MODE(cis_mode),
    .CIS_LED_RED(led_r), .CIS_LED_GREEN(led_g), .CIS_LED_BLUE(led_b),
    .ADC_CLK(adc_clk), .PIX_DATA(pix_data), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready), .PIX_FIRST(pix_first), .PIX_COLOR(pix_color),
    .OVERRUN(overrun), .SCOPE_SYNC(scope_sync)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line is just a cycle position 0..LINE_CYC-1; everything
  // else (periods, ticks, colours) is arithmetic on that position.
  bit               m_active, m_rgb, m_valid, m_first, m_over;
  bit               m_adc = 1'b1;
  int               m_pos, m_line;
  logic [ADC_W-1:0] m_data;
  logic [1:0]       m_color;

  function automatic bit cis_now();
    return m_active && ((m_pos % CLK_DIV) < CLK_DIV / 2);
  endfunction

  always @(posedge usb_clk) begin : ref_model
    int per;
    bit cap;
    if (rst) begin
      m_active = 0; m_pos = 0; m_line = 0; m_rgb = 0; m_adc = 1;
      m_valid = 0; m_first = 0; m_over = 0; m_data = '0; m_color = 2'd0;
    end else begin
      per = m_pos / CLK_DIV;
      cap = m_active && (m_pos % CLK_DIV == CLK_DIV - 1) &&
            (per >= 1 + ADC_LAT) && (per <= PIXELS + ADC_LAT);
      m_adc = !cis_now();
      if (cap) begin
        if (m_valid && !pix_ready) m_over = 1;
        else begin
          m_valid = 1;
          m_data  = adc_data;
          m_first = (per == 1 + ADC_LAT);
          m_color = m_rgb ? 2'(m_line % 3) : 2'd3;
        end
      end else if (m_valid && pix_ready) begin
        m_valid = 0;
      end
      if (m_active) begin
        if (m_pos == LINE_CYC - 1) begin
          if (enable) begin m_pos = 0; m_line++; m_rgb = color_mode; end
          else m_active = 0;
        end else m_pos++;
      end else if (enable) begin
        m_active = 1; m_pos = 0; m_line = 0; m_rgb = color_mode;
      end
    end
  end

  int cyc = 0, last_rise = -1, sp_len = 0, beats = 0;
  bit prev_sp = 0, beats_valid = 0;

  always @(negedge usb_clk) begin : monitor
    logic [1:0] c;
    bit lit;
    cyc++;
    lit = m_active;
    c   = 2'(m_line % 3);
    check_val("cis_clk", cis_clk, cis_now());
    check_val("cis_sp", cis_sp, m_active && (m_pos < CLK_DIV));
    check_val("scope_sync", scope_sync, m_active && (m_pos < CLK_DIV));
    check_val("cis_mode", cis_mode, 1);
    check_val("adc_clk", adc_clk, m_adc);
    check_val("led_r", led_r, lit && (!m_rgb || c == 2'd0));
    check_val("led_g", led_g, lit && (!m_rgb || c == 2'd1));
    check_val("led_b", led_b, lit && (!m_rgb || c == 2'd2));
    check_val("pix_valid", pix_valid, m_valid);
    check_val("pix_data", pix_data, m_data);
    check_val("pix_first", pix_first, m_first);
    check_val("pix_color", pix_color, m_color);
    check_val("overrun", overrun, m_over);

    if (cis_sp && !prev_sp) begin
      if (measure && last_rise >= 0) check_val("line_period", cyc - last_rise, LINE_CYC);
      if (measure && beats_valid)    check_val("beats_per_line", beats, PIXELS);
      last_rise   = measure ? cyc : -1;
      beats       = 0;
      beats_valid = measure;
    end
    if (cis_sp) sp_len++;
    else begin
      if (prev_sp && measure) check_val("sp_width", sp_len, CLK_DIV);
      sp_len = 0;
    end
    if (pix_valid && pix_ready) begin
      if (measure) begin
        check_val("first_flag", pix_first, beats == 0);
        check_val("ramp_data", pix_data, beats + 2);
        check_val("leds_mono", {led_r, led_g, led_b}, 3'b111);
      end
      if (rgb_watch && pix_first) begin
        check_val("rgb_color", pix_color, rgb_idx % 3);
        check_val("rgb_led", {led_r, led_g, led_b}, 3'b100 >> (rgb_idx % 3));
        rgb_idx++;
      end
      beats++;
    end
    prev_sp = cis_sp;
  end

  // ADC source: ramp value k during READ period k, else random
  initial begin
    forever begin
      @(posedge usb_clk);
      #1;
      if (ramp_mode)
        adc_data = (m_active && m_pos >= CLK_DIV) ? ADC_W'(m_pos / CLK_DIV - 1) : '0;
      else
        adc_data = ADC_W'($urandom);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge usb_clk); #2; end
  endtask

  task automatic wait_pos(input int p);
    bit found = 0;
    for (int i = 0; i < 4 * LINE_CYC && !found; i++) begin
      @(posedge usb_clk); #2;
      found = m_active && (m_pos == p);
    end
    check_val("pos_reached", found, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * LINE_CYC && m_active; i++) begin
      @(posedge usb_clk); #2;
    end
    @(negedge usb_clk);
    check_val("idle_outputs", {cis_sp, cis_clk, led_r, led_g, led_b}, 5'b0);
    @(posedge usb_clk); #2;
  endtask

  localparam int PIX5_POS = (1 + ADC_LAT + 5) * CLK_DIV;
  localparam int PIX8_POS = (1 + ADC_LAT + 8) * CLK_DIV;

  initial begin
    int stall_left = 0;
    step(3);
    rst = 0;
    @(negedge usb_clk);
    check_val("rst_cis_sp", cis_sp, 0);
    check_val("rst_adc_clk", adc_clk, 1);
    check_val("rst_cis_mode", cis_mode, 1);
    check_val("rst_leds", {led_r, led_g, led_b}, 3'b000);
    check_val("rst_pix_valid", pix_valid, 0);
    step(1);

    // mono ramp lines
    measure = 1;
    enable  = 1;
    step(4 * LINE_CYC + 8);
    measure = 0;

    // RGB sequence from a fresh start
    enable = 0;
    wait_idle();
    color_mode = 1; rgb_idx = 0; rgb_watch = 1;
    enable = 1;
    step(4 * LINE_CYC - 20);
    rgb_watch = 0;
    check_val("rgb_lines_seen", rgb_idx, 4);

    // downstream stall mid-line
    color_mode = 0;
    wait_pos(PIX5_POS);
    pix_ready = 0;
    step(10 * CLK_DIV);
    @(negedge usb_clk);
    check_val("stall_overrun", overrun, 1);
    pix_ready = 1;
    step(2 * LINE_CYC);
    @(negedge usb_clk);
    check_val("overrun_sticky", overrun, 1);

    // enable dropped mid-line, then restart in RGB
    wait_pos(PIX5_POS);
    enable = 0;
    wait_idle();
    step(10);
    color_mode = 1; rgb_idx = 0; rgb_watch = 1;
    enable = 1;
    step(30);
    rgb_watch = 0;

    // reset mid-line
    wait_pos(PIX8_POS);
    rst = 1;
    @(posedge usb_clk);
    @(negedge usb_clk);
    check_val("midrst_valid", pix_valid, 0);
    check_val("midrst_overrun", overrun, 0);
    check_val("midrst_sp_clk", {cis_sp, cis_clk}, 2'b00);
    check_val("midrst_adc_clk", adc_clk, 1);
    check_val("midrst_leds", {led_r, led_g, led_b}, 3'b000);
    #3 rst = 0;
    step(LINE_CYC);

    // randomized traffic
    ramp_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge usb_clk); #2;
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 299) == 0) enable = !enable;
      if ($urandom_range(0, 199) == 0) color_mode = !color_mode;
      if (stall_left > 0) begin
        pix_ready = 0;
        stall_left--;
      end else if ($urandom_range(0, 99) == 0) begin
        stall_left = $urandom_range(1, 40);
        pix_ready  = 0;
      end else begin
        pix_ready = ($urandom_range(0, 7) != 0);
      end
    end
    rst = 0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cis_scan_ctrl.md
# cis_scan_ctrl

Parametrised contact-image-sensor line-scan controller, generalising the current fixed single-configuration scan path. Runs in the USB_CLK domain. Generates CIS_CLK, CIS_SP, ADC_CLK and LED drive. Captures one ADC_DATA sample per pixel, compensates for ADC pipeline latency, and presents pixels on a valid/ready stream toward the USB packer, with monochrome or RGB-sequential illumination modes.

## Interface
- CLK_DIV, 4: USB_CLK cycles per CIS pixel clock; even, ≥2.
- PIXELS, 2592: valid pixels per line.
- ADC_W, 8: ADC sample width.
- ADC_LAT, 2: ADC pipeline latency in pixel periods, 0..7.
- INT_PAD, 8: idle pixel periods after each line (integration padding).

Ports:
- USB_CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  scan enable; sampled at line boundaries.
- COLOR_MODE  in  1  0 = mono (R+G+B lit), 1 = RGB sequential; sampled at line start.
- ADC_DATA  in  ADC_W  ADC output bus.
- CIS_CLK  out  1  sensor pixel clock.
- CIS_SP  out  1  sensor start pulse.
- CIS_MODE  out  1  sensor resolution select; tied 1.
- CIS_LED_RED / CIS_LED_GREEN / CIS_LED_BLUE  out  1 each  illumination.
- ADC_CLK  out  1  ADC conversion clock.
- PIX_DATA  out  ADC_W  captured pixel.
- PIX_VALID  out  1  PIX_DATA valid.
- PIX_READY  in  1  downstream accepts when PIX_VALID && PIX_READY.
- PIX_FIRST  out  1  qualifies first pixel of a line.
- PIX_COLOR  out  2  0 = R, 1 = G, 2 = B, 3 = mono; constant for the line.
- OVERRUN  out  1  sticky: a pixel was dropped.
- SCOPE_SYNC  out  1  copy of CIS_SP for the oscilloscope trigger.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 while not IDLE. Pixel tick = (div_cnt == CLK_DIV-1). CIS_CLK = 1 while div_cnt < CLK_DIV/2. ADC_CLK = ~CIS_CLK, registered.
- States:
  - IDLE -> SP when ENABLE=1.
  - SP: one pixel period, CIS_SP=1 -> READ.
  - READ: PIXELS+ADC_LAT pixel periods -> PAD.
  - PAD: INT_PAD periods; skipped if INT_PAD=0.
  - At end of PAD: -> SP if ENABLE=1, else IDLE.
- ENABLE deassert mid-line: the line completes through PAD, then IDLE. No partial lines.
- Capture: on each READ pixel tick, ADC_DATA is registered. The first ADC_LAT ticks of READ are discarded. The remaining PIXELS samples are emitted. Pixel index resets in SP.
- Stream:
  - A captured sample loads PIX_DATA and sets PIX_VALID.
  - PIX_VALID holds with stable PIX_DATA/PIX_FIRST/PIX_COLOR until the handshake completes.
  - If a new sample arrives while PIX_VALID=1 and PIX_READY=0, the new sample is dropped and OVERRUN is set. OVERRUN clears only on RST.
  - Handshake and new-load in the same cycle: load wins, PIX_VALID stays 1.
- PIX_FIRST = 1 with pixel index 0 of each line.
- LEDs:
  - Off in IDLE.
  - Mono: all three on in SP/READ/PAD.
  - RGB: only the LED of the current colour is lit. Colour advances R->G->B->R at each SP entry after the first line.
  - COLOR_MODE change takes effect at the next SP.
  - Colour pointer resets to R on RST or on IDLE entry.

## Timing
- Reset values: all outputs 0 except CIS_MODE=1 and ADC_CLK=1. div_cnt=0, state=IDLE, colour=R.
- IDLE->SP: CIS_SP rises the cycle after ENABLE is sampled 1.
- Line period = (1 + PIXELS + ADC_LAT + INT_PAD) × CLK_DIV USB_CLK cycles.
- Capture latency: PIX_VALID rises 1 cycle after the capturing pixel tick.
- RST mid-line: next cycle all outputs at reset values. The pending pixel is discarded.

## Test plan
- Params CLK_DIV=4, PIXELS=16, ADC_LAT=2, INT_PAD=3; ENABLE=1, PIX_READY=1, COLOR_MODE=0; ADC_DATA = ramp that increments each pixel tick, starting at 0x00 on the first READ tick.
  - Expect per line: 1 CIS_SP period of 4 cycles and 16 PIX_VALID beats with data 0x02..0x11.
  - Expect PIX_FIRST on the first beat, line period 88 cycles, all LEDs on.
- COLOR_MODE=1 over 4 lines -> PIX_COLOR and lit LED sequence R,G,B,R.
- PIX_READY=0 for 10 pixel periods mid-line -> first stalled pixel held stable, OVERRUN=1, remaining pixels of the line dropped. OVERRUN stays 1 until RST.
- ENABLE dropped at pixel 5 -> line finishes through PAD, then IDLE with LEDs off. Re-enable restarts with colour R.
- RST asserted at pixel 8 -> next cycle all outputs at reset values. No PIX_VALID until a new SP.
